// File: rtl/apb_master_mc.sv
// apb_master_mc: single-outstanding APB master fed by a simple valid/ready request port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_write/req_size       direction and access size (1 << size bytes)
//   req_addr/req_wdata       byte address (top 8 bits select the slave), right-aligned data
//   rsp_valid/rsp_err        one-cycle response pulse and its error flag
//   rsp_rdata                right-aligned, size-masked read data
//   psel..pstrb              APB request signals towards NUM_SLV slaves
//   prdata/pready/pslverr    per-slave APB responses (slave i at slice/bit i)
module apb_master_mc #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_SLV     = 4,
  parameter logic [7:0]  BASE_HI     = 8'h40,
  parameter int unsigned TIMEOUT_CYC = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [1:0]                    req_size,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  output logic                          rsp_valid,
  output logic                          rsp_err,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [NUM_SLV-1:0]            psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic [DATA_WIDTH/8-1:0]       pstrb,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLV-1:0]            pready,
  input  logic [NUM_SLV-1:0]            pslverr
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(STRB_W);
  localparam int unsigned OFF_W  = ADDR_WIDTH - 8;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;

  // Captured request; only the in-region offset is kept, the tag lives on as r_sel.
  logic                    r_write;
  logic [1:0]              r_size;
  logic [OFF_W-1:0]        r_off;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [NUM_SLV-1:0]      r_sel;
  logic [7:0]              r_cnt;
  logic                    r_rsp_valid;
  logic                    r_rsp_err;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;

  // Request-side decode (evaluated in the acceptance cycle)
  logic [7:0]              w_tag;
  logic [NUM_SLV-1:0]      w_dec_sel;
  logic [LANE_W-1:0]       w_req_lane;
  logic [LANE_W-1:0]       w_align_mask;
  logic                    w_misalign;
  logic                    w_dec_ok;

  // Transfer-side datapath
  logic [LANE_W-1:0]       w_lane;
  logic [LANE_W+2:0]       w_shamt;
  logic [STRB_W-1:0]       w_byte_en;
  logic [STRB_W-1:0]       w_strb;
  logic [DATA_WIDTH-1:0]   w_rd_mask;
  logic [DATA_WIDTH-1:0]   w_slice;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_sel_ready;
  logic                    w_sel_err;
  logic                    w_timeout;

  assign w_tag      = req_addr[ADDR_WIDTH-1 -: 8];
  assign w_req_lane = req_addr[LANE_W-1:0];

  // 9-bit compare so BASE_HI+i never wraps onto a low tag.
  always_comb begin
    w_dec_sel = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if ({1'b0, w_tag} == 9'(int'(BASE_HI) + i)) w_dec_sel[i] = 1'b1;
    end
  end

  assign w_align_mask = LANE_W'((32'd1 << req_size) - 32'd1);
  assign w_misalign   = ((w_req_lane & w_align_mask) != '0) ||
                        ((req_size == 2'd3) && (DATA_WIDTH == 32));
  assign w_dec_ok     = (|w_dec_sel) && !w_misalign;

  assign w_lane  = r_off[LANE_W-1:0];
  assign w_shamt = {w_lane, 3'b000};

  always_comb begin
    w_byte_en = '0;
    w_rd_mask = '0;
    for (int b = 0; b < int'(STRB_W); b++) begin
      w_byte_en[b]        = (b < (1 << r_size));
      w_rd_mask[b*8 +: 8] = {8{w_byte_en[b]}};
    end
  end

  assign w_strb = w_byte_en << w_lane;

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (r_sel[i]) w_slice = prdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_rdata     = (w_slice >> w_shamt) & w_rd_mask;
  assign w_sel_ready = |(pready & r_sel);
  assign w_sel_err   = |(pslverr & r_sel);
  // r_cnt holds the number of ACCESS cycles already spent before the current one.
  assign w_timeout   = !w_sel_ready && (r_cnt == 8'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (req_valid && w_dec_ok) w_state_nxt = StSetup;
      StSetup:  w_state_nxt = StAccess;
      StAccess: if (w_sel_ready || w_timeout) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Output logic: every APB signal is zero while idle.
  always_comb begin
    req_ready = 1'b0;
    psel      = '0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    pstrb     = '0;
    case (r_state)
      StIdle: req_ready = 1'b1;
      StSetup, StAccess: begin
        psel    = r_sel;
        penable = (r_state == StAccess);
        pwrite  = r_write;
        paddr   = {8'h00, r_off};
        pwdata  = r_write ? (r_wdata << w_shamt) : '0;
        pstrb   = (r_write && (r_state == StAccess)) ? w_strb : '0;
      end
      default: ;
    endcase
  end

  // Request capture, ACCESS counter and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write     <= 1'b0;
      r_size      <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_write <= req_write;
            r_size  <= req_size;
            r_off   <= req_addr[OFF_W-1:0];
            r_wdata <= req_wdata;
            r_sel   <= w_dec_sel;
            r_cnt   <= '0;
            if (!w_dec_ok) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        StAccess: begin
          if (w_sel_ready) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_sel_err;
            r_rsp_rdata <= (r_write || w_sel_err) ? '0 : w_rdata;
          end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master_mc.sv
// tb_apb_master_mc: table-driven and randomized checks of apb_master_mc with default parameters.
module tb_apb_master_mc;

  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [1:0]   req_size;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         rsp_valid;
  logic         rsp_err;
  logic [31:0]  rsp_rdata;
  logic [3:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [127:0] prdata;
  logic [3:0]   pready;
  logic [3:0]   pslverr;

  int n_cmp  = 0;
  int n_fail = 0;

  apb_master_mc dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          wait_cyc;   // ACCESS cycles with pready low before ready; >= TMO never ready
    logic        dec_err;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  psel;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: expected APB/response behaviour from the address map and size rules.
  function automatic vec_t model(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] prd,
                                 input logic serr, input int wt);
    vec_t v;
    int tag, lane, nb;
    logic [63:0] m;
    tag  = int'(addr[31:24]);
    lane = int'(addr[1:0]);
    nb   = 1 << sz;
    v.write = wr; v.size = sz; v.addr = addr; v.wdata = wd; v.prdata = prd;
    v.slverr = serr; v.wait_cyc = wt;
    v.dec_err = (tag < 'h40) || (tag >= 'h44) || (sz == 2'd3) || ((lane % nb) != 0);
    v.psel    = v.dec_err ? 4'd0 : 4'(1 << (tag - 'h40));
    v.pwdata  = (!v.dec_err && wr) ? 32'(64'(wd) << (8 * lane)) : 32'd0;
    v.pstrb   = (!v.dec_err && wr) ? 4'(((1 << nb) - 1) << lane) : 4'd0;
    v.exp_err = v.dec_err || serr || (wt >= TMO);
    m = (64'd1 << (8 * nb)) - 64'd1;
    v.exp_rdata = (wr || v.exp_err) ? 32'd0 : 32'((64'(prd) >> (8 * lane)) & m);
    return v;
  endfunction

  // Runs one request from acceptance to response, acting as all four slaves.
  task automatic apply(input vec_t v, input string nm);
    logic [31:0] epaddr;
    epaddr = {8'h00, v.addr[23:0]};
    chk({nm, ".req_ready"}, 64'(req_ready), 64'(1'b1));
    req_valid = 1'b1;
    req_write = v.write;
    req_size  = v.size;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom();
    req_addr  = $urandom();
    if (v.dec_err) begin
      chk({nm, ".rsp_valid"}, 64'(rsp_valid), 64'(1'b1));
      chk({nm, ".rsp_err"},   64'(rsp_err),   64'(1'b1));
      chk({nm, ".rsp_rdata"}, 64'(rsp_rdata), 64'(32'd0));
      chk({nm, ".psel"},      64'(psel),      64'(4'd0));
      return;
    end
    // SETUP: every slave, selected one included, claims ready/error; all must be ignored.
    chk({nm, ".s.psel"},    64'(psel),      64'(v.psel));
    chk({nm, ".s.penable"}, 64'(penable),   64'(1'b0));
    chk({nm, ".s.pwrite"},  64'(pwrite),    64'(v.write));
    chk({nm, ".s.paddr"},   64'(paddr),     64'(epaddr));
    chk({nm, ".s.pwdata"},  64'(pwdata),    64'(v.pwdata));
    chk({nm, ".s.pstrb"},   64'(pstrb),     64'(4'd0));
    chk({nm, ".s.rsp"},     64'(rsp_valid), 64'(1'b0));
    for (int i = 0; i < 4; i++) prdata[i*32 +: 32] = v.psel[i] ? v.prdata : $urandom();
    pready  = 4'hF;
    pslverr = 4'hF;
    @(posedge clk); #1;
    for (int k = 0; k < TMO; k++) begin
      chk({nm, $sformatf(".a%0d.penable", k)}, 64'(penable),   64'(1'b1));
      chk({nm, $sformatf(".a%0d.psel", k)},    64'(psel),      64'(v.psel));
      chk({nm, $sformatf(".a%0d.pwdata", k)},  64'(pwdata),    64'(v.pwdata));
      chk({nm, $sformatf(".a%0d.pstrb", k)},   64'(pstrb),     64'(v.pstrb));
      chk({nm, $sformatf(".a%0d.paddr", k)},   64'(paddr),     64'(epaddr));
      chk({nm, $sformatf(".a%0d.rsp", k)},     64'(rsp_valid), 64'(1'b0));
      if (k == v.wait_cyc) begin
        pready  = 4'hF;
        pslverr = ~v.psel | (v.slverr ? v.psel : 4'h0);
      end else begin
        pready  = ~v.psel;
        pslverr = 4'hF;
      end
      @(posedge clk); #1;
      if (k == v.wait_cyc) break;
    end
    pready  = 4'h0;
    pslverr = 4'h0;
    chk({nm, ".rsp_valid"}, 64'(rsp_valid), 64'(1'b1));
    chk({nm, ".rsp_err"},   64'(rsp_err),   64'(v.exp_err));
    chk({nm, ".rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
    chk({nm, ".e.psel"},    64'(psel),      64'(4'd0));
    chk({nm, ".e.penable"}, 64'(penable),   64'(1'b0));
    chk({nm, ".e.pstrb"},   64'(pstrb),     64'(4'd0));
  endtask

  vec_t dir [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    // write, size, addr, wdata, prdata, slverr, wait, dec_err, exp_err, rdata, psel, pwdata, pstrb
    dir[0]  = '{1'b1, 2'd2, 32'h4100_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1,
                1'b0, 1'b0, 32'h0, 4'b0010, 32'hDEAD_BEEF, 4'hF};
    dir[1]  = '{1'b0, 2'd0, 32'h4000_0003, 32'h0, 32'hAB00_0000, 1'b0, 0,
                1'b0, 1'b0, 32'h0000_00AB, 4'b0001, 32'h0, 4'h0};
    dir[2]  = '{1'b1, 2'd1, 32'h4200_0002, 32'h0000_1234, 32'h0, 1'b0, 0,
                1'b0, 1'b0, 32'h0, 4'b0100, 32'h1234_0000, 4'hC};
    dir[3]  = '{1'b1, 2'd1, 32'h4200_0001, 32'h0000_1234, 32'h0, 1'b0, 0,
                1'b1, 1'b1, 32'h0, 4'b0000, 32'h0, 4'h0};
    dir[4]  = '{1'b0, 2'd2, 32'h5000_0000, 32'h0, 32'h0, 1'b0, 0,
                1'b1, 1'b1, 32'h0, 4'b0000, 32'h0, 4'h0};
    dir[5]  = '{1'b0, 2'd2, 32'h4300_0008, 32'h0, 32'h1111_2222, 1'b0, 4,
                1'b0, 1'b1, 32'h0, 4'b1000, 32'h0, 4'h0};
    dir[6]  = '{1'b0, 2'd2, 32'h4100_0004, 32'h0, 32'h1234_5678, 1'b1, 1,
                1'b0, 1'b1, 32'h0, 4'b0010, 32'h0, 4'h0};
    dir[7]  = '{1'b0, 2'd3, 32'h4000_0000, 32'h0, 32'h0, 1'b0, 0,
                1'b1, 1'b1, 32'h0, 4'b0000, 32'h0, 4'h0};
    dir[8]  = '{1'b0, 2'd1, 32'h4300_0002, 32'h0, 32'hCAFE_BEEF, 1'b0, 2,
                1'b0, 1'b0, 32'h0000_CAFE, 4'b1000, 32'h0, 4'h0};
    dir[9]  = '{1'b0, 2'd2, 32'h3F00_0000, 32'h0, 32'h0, 1'b0, 0,
                1'b1, 1'b1, 32'h0, 4'b0000, 32'h0, 4'h0};
    dir[10] = '{1'b1, 2'd0, 32'h4000_0001, 32'h0000_005A, 32'h0, 1'b0, 0,
                1'b0, 1'b0, 32'h0, 4'b0001, 32'h0000_5A00, 4'b0010};
    dir[11] = '{1'b0, 2'd2, 32'h4000_0000, 32'h0, 32'h89AB_CDEF, 1'b0, 3,
                1'b0, 1'b0, 32'h89AB_CDEF, 4'b0001, 32'h0, 4'h0};
    dir[12] = '{1'b1, 2'd2, 32'h4200_0000, 32'hFFFF_0000, 32'h0, 1'b1, 0,
                1'b0, 1'b1, 32'h0, 4'b0100, 32'hFFFF_0000, 4'hF};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_addr = 32'h0; req_wdata = 32'h0; prdata = '0; pready = 4'h0; pslverr = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.req_ready", 64'(req_ready), 64'(1'b1));
    chk("reset.rsp_valid", 64'(rsp_valid), 64'(1'b0));
    chk("reset.rsp_err",   64'(rsp_err),   64'(1'b0));
    chk("reset.rsp_rdata", 64'(rsp_rdata), 64'(32'd0));
    chk("reset.psel",      64'(psel),      64'(4'd0));
    chk("reset.penable",   64'(penable),   64'(1'b0));
    chk("reset.pwrite",    64'(pwrite),    64'(1'b0));
    chk("reset.paddr",     64'(paddr),     64'(32'd0));
    chk("reset.pwdata",    64'(pwdata),    64'(32'd0));
    chk("reset.pstrb",     64'(pstrb),     64'(4'd0));

    // Directed table; consecutive entries are issued back-to-back in the response cycle.
    for (int i = 0; i < 13; i++) apply(dir[i], $sformatf("dir%0d", i));

    // Reset while in ACCESS abandons the transfer without a response.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
    req_addr = 32'h4100_0000; req_wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstmid.setup.psel", 64'(psel), 64'(4'b0010));
    @(posedge clk); #1;
    chk("rstmid.access.penable", 64'(penable), 64'(1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid.psel",      64'(psel),      64'(4'd0));
    chk("rstmid.penable",   64'(penable),   64'(1'b0));
    chk("rstmid.rsp_valid", 64'(rsp_valid), 64'(1'b0));
    chk("rstmid.req_ready", 64'(req_ready), 64'(1'b1));
    @(posedge clk); #1;
    chk("rstmid.after.rsp_valid", 64'(rsp_valid), 64'(1'b0));
    chk("rstmid.after.psel",      64'(psel),      64'(4'd0));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      vec_t v;
      a = {8'(8'h3E + ($urandom() % 8)), 24'($urandom())};
      v = model(1'($urandom()), 2'($urandom()), a, $urandom(), $urandom(),
                ($urandom() % 4) == 0, int'($urandom() % 6));
      apply(v, $sformatf("rnd%0d", i));
      if ($urandom() % 2 == 1) begin
        @(posedge clk); #1;
        chk($sformatf("rnd%0d.idle.rsp_valid", i), 64'(rsp_valid), 64'(1'b0));
        chk($sformatf("rnd%0d.idle.psel", i),      64'(psel),      64'(4'd0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
